// File: rtl/cache_victim_buf_pkg.sv
// Shared cache definitions: victim-buffer state encoding.
package cache_victim_buf_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } evict_state_e;

endpackage

// File: rtl/cache_way_linemux.sv
// One-hot way select: ORs the line slices of every selected way.
module cache_way_linemux #(
    parameter int NUMWAYS = 4,
    parameter int LINELEN = 256
) (
    input  logic [NUMWAYS-1:0]         i_way_sel,
    input  logic [NUMWAYS*LINELEN-1:0] i_lines,
    output logic [LINELEN-1:0]         o_line
);

    always_comb begin
        o_line = '0;
        for (int i = 0; i < NUMWAYS; i++)
            o_line = o_line | (i_lines[i*LINELEN +: LINELEN] & {LINELEN{i_way_sel[i]}});
    end

endmodule

// File: rtl/cache_victim_buf.sv
// Single-entry victim buffer: captures a dirty evicted line and drains it as
// bus write beats; clean victims complete immediately with no bus traffic.
module cache_victim_buf
    import cache_victim_buf_pkg::*;
#(
    parameter int NUMWAYS = 4,
    parameter int LINELEN = 256,
    parameter int BEATLEN = 64,
    parameter int PA_BITS = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       EvictReq,
    output logic                       EvictReady,
    input  logic [NUMWAYS-1:0]         VictimWay,
    input  logic [NUMWAYS-1:0]         VictimDirtyWay,
    input  logic [NUMWAYS*LINELEN-1:0] ReadDataLineWay,
    input  logic [PA_BITS-1:0]         EvictAdr,
    output logic                       BusValid,
    input  logic                       BusReady,
    output logic [PA_BITS-1:0]         BusAdr,
    output logic [BEATLEN-1:0]         BusData,
    output logic                       BusLast,
    output logic                       EvictDone,
    input  logic [PA_BITS-1:0]         SnoopAdr,
    output logic                       SnoopHit
);

    localparam int BEATS     = LINELEN / BEATLEN;
    localparam int OFFSETLEN = $clog2(LINELEN / 8);
    localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [PA_BITS-1:0] LINE_MASK =
        {{(PA_BITS-OFFSETLEN){1'b1}}, {OFFSETLEN{1'b0}}};

    evict_state_e        r_state;
    logic [BEAT_W-1:0]   r_beat;
    logic                r_done;
    logic [LINELEN-1:0]  r_line;
    logic [PA_BITS-1:0]  r_base;

    logic [LINELEN-1:0]  w_line;
    logic                w_accept;
    logic                w_dirty;
    logic                w_last;
    logic [PA_BITS-1:0]  w_snoop_diff;

    cache_way_linemux #(
        .NUMWAYS (NUMWAYS),
        .LINELEN (LINELEN)
    ) u_linemux (
        .i_way_sel (VictimWay),
        .i_lines   (ReadDataLineWay),
        .o_line    (w_line)
    );

    // A zero or multi-hot way select is treated as clean: nothing trustworthy to write back.
    assign w_accept = EvictReq && (r_state == IDLE);
    assign w_dirty  = $onehot(VictimWay) && ((VictimDirtyWay & VictimWay) != '0);
    assign w_last   = (r_beat == BEAT_W'(BEATS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_beat  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_beat <= '0;
                        if (w_dirty) r_state <= DRAIN;
                        else         r_done  <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (BusReady) begin
                        if (w_last) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_beat <= r_beat + BEAT_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Payload needs no reset; it is only observed while in DRAIN.
    always_ff @(posedge clk) begin
        if (w_accept && w_dirty) begin
            r_line <= w_line;
            r_base <= EvictAdr & LINE_MASK;
        end
    end

    assign w_snoop_diff = (SnoopAdr ^ r_base) & LINE_MASK;

    assign EvictReady = (r_state == IDLE);
    assign EvictDone  = r_done;
    assign BusValid   = (r_state == DRAIN);
    assign BusLast    = (r_state == DRAIN) && w_last;
    assign BusData    = r_line[r_beat*BEATLEN +: BEATLEN];
    assign BusAdr     = r_base + PA_BITS'(r_beat) * PA_BITS'(BEATLEN / 8);
    assign SnoopHit   = (r_state == DRAIN) && (w_snoop_diff == '0);

endmodule

// File: tb/tb_cache_victim_buf.sv
// Self-checking bench for cache_victim_buf: vector table, random evictions
// against a line/beat model, and hand-built backpressure/snoop/reset/b2b cases.
module tb_cache_victim_buf;

    localparam int NUMWAYS = 4;
    localparam int LINELEN = 256;
    localparam int BEATLEN = 64;
    localparam int PA_BITS = 32;
    localparam int BEATS   = LINELEN / BEATLEN;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       EvictReq;
    logic                       EvictReady;
    logic [NUMWAYS-1:0]         VictimWay;
    logic [NUMWAYS-1:0]         VictimDirtyWay;
    logic [NUMWAYS*LINELEN-1:0] rdl;
    logic [PA_BITS-1:0]         EvictAdr;
    logic                       BusValid;
    logic                       BusReady;
    logic [PA_BITS-1:0]         BusAdr;
    logic [BEATLEN-1:0]         BusData;
    logic                       BusLast;
    logic                       EvictDone;
    logic [PA_BITS-1:0]         SnoopAdr;
    logic                       SnoopHit;

    int n_checks = 0;
    int n_fail   = 0;

    cache_victim_buf #(
        .NUMWAYS (NUMWAYS), .LINELEN (LINELEN), .BEATLEN (BEATLEN), .PA_BITS (PA_BITS)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .EvictReq        (EvictReq),
        .EvictReady      (EvictReady),
        .VictimWay       (VictimWay),
        .VictimDirtyWay  (VictimDirtyWay),
        .ReadDataLineWay (rdl),
        .EvictAdr        (EvictAdr),
        .BusValid        (BusValid),
        .BusReady        (BusReady),
        .BusAdr          (BusAdr),
        .BusData         (BusData),
        .BusLast         (BusLast),
        .EvictDone       (EvictDone),
        .SnoopAdr        (SnoopAdr),
        .SnoopHit        (SnoopHit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  way;
        logic [3:0]  dway;
        logic [31:0] adr;
        bit          exp_dirty;
        logic [31:0] exp_base;
        int          exp_way;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_dirty(input logic [3:0] way, input logic [3:0] dway);
        return ($countones(way) == 1) && ((way & dway) != 4'b0);
    endfunction

    function automatic int way_index(input logic [3:0] way);
        int idx = 0;
        for (int i = 0; i < NUMWAYS; i++) if (way[i]) idx = i;
        return idx;
    endfunction

    task automatic new_lines();
        for (int i = 0; i < NUMWAYS*LINELEN/32; i++) rdl[i*32 +: 32] = $urandom();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called one tick after an edge with the buffer idle; returns one tick after the accept edge.
    task automatic do_accept(input logic [3:0] way, input logic [3:0] dway,
                             input logic [31:0] adr, input bit hold);
        VictimWay      = way;
        VictimDirtyWay = dway;
        EvictAdr       = adr;
        EvictReq       = 1'b1;
        #1;
        chk("ready_idle", EvictReady, 1);
        step();
        if (!hold) EvictReq = 1'b0;
    endtask

    // mode: -2 always ready, -1 random ready, >=0 stall that beat for stall_n cycles.
    task automatic drain_check(input logic [31:0] base, input int w, input int mode, input int stall_n);
        int  k;
        int  cyc;
        int  stalls;
        int  st_left;
        logic rdy;
        k = 0; cyc = 0; stalls = 0; st_left = stall_n;
        while (k < BEATS && cyc < 100) begin
            if (mode == -2)      rdy = 1'b1;
            else if (mode == -1) rdy = ($urandom_range(0, 2) != 0);
            else begin
                rdy = !(k == mode && st_left > 0);
                if (!rdy) st_left--;
            end
            if (!rdy) stalls++;
            BusReady = rdy;
            SnoopAdr = ($urandom_range(0, 1) == 1) ? base + 32'($urandom_range(0, 31)) : 32'($urandom());
            #1;
            chk("bus_valid", BusValid, 1);
            chk("bus_adr", BusAdr, base + 32'(k * (BEATLEN / 8)));
            chk("bus_data", BusData, rdl[w*LINELEN + k*BEATLEN +: BEATLEN]);
            chk("bus_last", BusLast, (k == BEATS - 1));
            chk("ready_busy", EvictReady, 0);
            chk("done_busy", EvictDone, 0);
            chk("snoop_drain", SnoopHit, (SnoopAdr[31:5] == base[31:5]));
            step();
            cyc++;
            if (rdy) k++;
        end
        BusReady = 1'b0;
        chk("drain_cycles", 64'(cyc), 64'(BEATS + stalls));
        chk("done_pulse", EvictDone, 1);
        chk("valid_after", BusValid, 0);
        chk("ready_after", EvictReady, 1);
    endtask

    task automatic clean_check();
        chk("clean_done", EvictDone, 1);
        chk("clean_nobus", BusValid, 0);
        step();
        chk("clean_once", EvictDone, 0);
        chk("clean_nobus2", BusValid, 0);
    endtask

    task automatic tail_check();
        step();
        chk("done_once", EvictDone, 0);
    endtask

    initial begin
        logic [3:0]  way;
        logic [3:0]  dway;
        logic [31:0] adr;

        tbl[0] = '{4'b0100, 4'b0100, 32'h80000047, 1'b1, 32'h80000040, 2};
        tbl[1] = '{4'b0001, 4'b1110, 32'h80000047, 1'b0, 32'h0, 0};
        tbl[2] = '{4'b0011, 4'b0011, 32'h80000100, 1'b0, 32'h0, 0};
        tbl[3] = '{4'b0000, 4'b1111, 32'h80000200, 1'b0, 32'h0, 0};
        tbl[4] = '{4'b1000, 4'b1001, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFE0, 3};
        tbl[5] = '{4'b0010, 4'b0010, 32'h12345678, 1'b1, 32'h12345660, 1};

        reset = 1'b1; EvictReq = 1'b0; VictimWay = '0; VictimDirtyWay = '0;
        EvictAdr = '0; BusReady = 1'b0; SnoopAdr = '0;
        new_lines();
        #1;
        chk("rst_valid", BusValid, 0);
        chk("rst_last", BusLast, 0);
        chk("rst_snoop", SnoopHit, 0);
        chk("rst_ready", EvictReady, 1);
        chk("rst_done", EvictDone, 0);
        step(); step();
        reset = 1'b0;

        // Vector table
        for (int i = 0; i < 6; i++) begin
            new_lines();
            do_accept(tbl[i].way, tbl[i].dway, tbl[i].adr, 1'b0);
            if (tbl[i].exp_dirty) begin
                drain_check(tbl[i].exp_base, tbl[i].exp_way, (i == 0) ? -2 : -1, 0);
                tail_check();
            end else begin
                clean_check();
            end
        end

        // Random evictions against the model
        for (int n = 0; n < 25; n++) begin
            new_lines();
            if ($urandom_range(0, 3) != 0) way = 4'(1 << $urandom_range(0, 3));
            else                           way = 4'($urandom());
            dway = 4'($urandom());
            adr  = $urandom();
            do_accept(way, dway, adr, 1'b0);
            if (model_dirty(way, dway)) begin
                drain_check(adr & 32'hFFFFFFE0, way_index(way), -1, 0);
                tail_check();
            end else begin
                clean_check();
            end
        end

        // Backpressure: three stall cycles on beat 1
        new_lines();
        do_accept(4'b0100, 4'b0100, 32'h80000040, 1'b0);
        drain_check(32'h80000040, 2, 1, 3);
        tail_check();

        // Snoop during and after a drain
        new_lines();
        do_accept(4'b0100, 4'b0100, 32'h80000040, 1'b0);
        BusReady = 1'b0;
        SnoopAdr = 32'h8000005C; #1;
        chk("snoop_in_line", SnoopHit, 1);
        SnoopAdr = 32'h80000060; #1;
        chk("snoop_next_line", SnoopHit, 0);
        drain_check(32'h80000040, 2, -2, 0);
        SnoopAdr = 32'h8000005C; #1;
        chk("snoop_idle", SnoopHit, 0);
        tail_check();

        // Asynchronous reset after two beats have been accepted
        new_lines();
        do_accept(4'b0100, 4'b0100, 32'h80000040, 1'b0);
        BusReady = 1'b1;
        step(); step();
        chk("rst_mid_adr", BusAdr, 32'h80000050);
        BusReady = 1'b0;
        SnoopAdr = 32'h80000040;
        #2;
        reset = 1'b1;
        #1;
        chk("amid_valid", BusValid, 0);
        chk("amid_last", BusLast, 0);
        chk("amid_snoop", SnoopHit, 0);
        chk("amid_ready", EvictReady, 1);
        step();
        reset = 1'b0;
        chk("amid_nodone", EvictDone, 0);
        step();
        chk("amid_nodone2", EvictDone, 0);
        chk("amid_ready2", EvictReady, 1);
        chk("amid_valid2", BusValid, 0);

        // Back-to-back: second request held while the first drains
        new_lines();
        do_accept(4'b0100, 4'b0100, 32'h80000040, 1'b1);
        VictimWay = 4'b0010; VictimDirtyWay = 4'b0010; EvictAdr = 32'h90000020;
        drain_check(32'h80000040, 2, -2, 0);
        step();
        EvictReq = 1'b0;
        drain_check(32'h90000020, 1, -1, 0);
        tail_check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_victim_buf.md
CACHE_VICTIM_BUF -- requirements
Module: cache_victim_buf

Interface
REQ-001 Parameter NUMWAYS, default 4: ways per set.
REQ-002 Parameter LINELEN, default 256: bits per cache line.
REQ-003 Parameter BEATLEN, default 64: bits per bus beat; LINELEN divisible by BEATLEN.
REQ-004 Parameter PA_BITS, default 32: physical address width.
REQ-005 Ports, in order:
- clk  in  1  the only clock.
- reset  in  1  asynchronous, active-high.
- EvictReq  in  1  eviction request from the cache FSM.
- EvictReady  out  1  buffer can accept a request.
- VictimWay  in  NUMWAYS  one-hot way chosen by the replacement policy.
- VictimDirtyWay  in  NUMWAYS  per-way dirty bits of the addressed set.
- ReadDataLineWay  in  NUMWAYS*LINELEN  per-way line data; way i occupies bits [i*LINELEN +: LINELEN].
- EvictAdr  in  PA_BITS  line base address of the victim.
- BusValid  out  1  write beat valid.
- BusReady  in  1  bus accepts the beat.
- BusAdr  out  PA_BITS  byte address of the current beat.
- BusData  out  BEATLEN  current beat data.
- BusLast  out  1  final beat of the line.
- EvictDone  out  1  one-cycle pulse when the eviction completes.
- SnoopAdr  in  PA_BITS  address checked against the buffered line.
- SnoopHit  out  1  buffered dirty line matches SnoopAdr.

Function
REQ-006 The block SHALL define BEATS = LINELEN/BEATLEN and OFFSETLEN = log2(LINELEN/8).
REQ-007 The block SHALL use two states: IDLE and DRAIN. EvictReady SHALL equal (state == IDLE).
REQ-008 An accept SHALL occur on a rising edge when EvictReq & EvictReady.
REQ-009 At an accept, the selected line SHALL be the OR of ReadDataLineWay slices gated by VictimWay. The victim SHALL be dirty if (VictimDirtyWay & VictimWay) != 0 and VictimWay is exactly one-hot.
REQ-010 Dirty accept: the block SHALL capture the line and EvictAdr with its low OFFSETLEN bits zeroed, clear the beat counter, and go to DRAIN.
REQ-011 Clean accept (not dirty, zero VictimWay, or non-one-hot VictimWay): the block SHALL stay in IDLE, generate no bus traffic, and pulse EvictDone in the next cycle.
REQ-012 In DRAIN, BusValid SHALL be 1 and BusData SHALL be line[beat*BEATLEN +: BEATLEN].
REQ-013 BusAdr SHALL be base + beat*(BEATLEN/8).
REQ-014 BusLast SHALL be 1 when beat == BEATS-1.
REQ-015 The beat counter SHALL advance only when BusValid & BusReady. BusAdr, BusData and BusLast SHALL hold stable while BusReady is low.
REQ-016 On a handshake of the last beat, the block SHALL return to IDLE and pulse EvictDone in the following cycle.
REQ-017 EvictDone SHALL be registered and last exactly one cycle per accept.
REQ-018 A new accept SHALL be legal in the same cycle that EvictDone is high, giving back-to-back operation with no bubble beyond IDLE.
REQ-019 SnoopHit SHALL be combinational: (state == DRAIN) & (SnoopAdr[PA_BITS-1:OFFSETLEN] == base[PA_BITS-1:OFFSETLEN]).
REQ-020 SnoopHit SHALL be 0 in IDLE.
REQ-021 EvictReq in DRAIN SHALL be ignored (not queued). The requester SHALL hold it until EvictReady.
REQ-022 An accepted eviction SHALL never be aborted except by reset.

Reset
REQ-023 Asserting reset SHALL immediately force state = IDLE, beat = 0, EvictDone = 0, and the buffer-valid indication cleared, so that BusValid = 0, BusLast = 0, SnoopHit = 0 and EvictReady = 1.
REQ-024 Reset asserted mid-DRAIN SHALL drop the line silently with no EvictDone. Captured data and address registers need no reset.

Structure
REQ-025 The state enum typedef SHALL live in the shared cache package. BEATS and OFFSETLEN SHALL be module localparams derived from the parameters.
REQ-026 The one-hot way-select mux SHALL be a sub-module, cache_way_linemux (NUMWAYS, LINELEN), reusable by the cache read path.

Verification (NUMWAYS=4, LINELEN=256, BEATLEN=64, PA_BITS=32)
REQ-027 Dirty drain:
- Stimulus: VictimWay=0100, VictimDirtyWay=0100, EvictAdr=0x80000047, BusReady=1.
- Response: four beats at BusAdr 0x80000040/48/50/58 carrying way-2 bits [63:0]..[255:192]; BusLast only on the fourth beat; EvictDone one cycle after it.
REQ-028 Clean victim:
- Stimulus: VictimWay=0001, VictimDirtyWay=1110; separately, VictimWay=0011.
- Response: in both cases BusValid stays 0 and EvictDone pulses exactly once, one cycle after the accept.
REQ-029 Backpressure:
- Stimulus: BusReady low for 3 cycles during beat 1.
- Response: BusAdr=0x80000048 and BusData stable throughout; total transfer time 4+3 cycles.
REQ-030 Snoop:
- Stimulus: during a drain of 0x80000040, SnoopAdr=0x8000005C, then 0x80000060, then 0x8000005C again after EvictDone.
- Response: SnoopHit = 1, then 0, then 0.
REQ-031 Reset:
- Stimulus: assert reset asynchronously after beat 2 handshakes.
- Response: BusValid=0 before the next clock edge; no EvictDone; EvictReady=1 after release.
REQ-032 Back-to-back:
- Stimulus: second dirty EvictReq held high while the first drains.
- Response: second request accepted in the EvictDone cycle; its first beat follows in the next cycle.
